// File: rtl/glob_loader_pkg.sv
// Shared definitions for the scalar-side load sequencer: opcodes, instruction
// field positions and the loader FSM state encoding.
package glob_loader_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int unsigned OPC_MSB    = 23;
    localparam int unsigned OPC_LSB    = 20;
    localparam int unsigned RD_MSB     = 19;
    localparam int unsigned RD_LSB     = 16;
    localparam int unsigned REG_ADDR_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_WAIT_STEP = 3'd3,
        ST_HALTED    = 3'd4
    } state_e;

endpackage

// File: rtl/glob_instr_decode.sv
// Combinational decode of a scalar instruction word into LDI/HALT flags,
// destination register and immediate.
module glob_instr_decode
    import glob_loader_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH  = 16
) (
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic                   is_ldi,
    output logic                   is_halt,
    output logic [REG_ADDR_W-1:0]  rd,
    output logic [DATA_WIDTH-1:0]  imm
);

    logic [3:0] opcode;

    always_comb begin
        opcode  = instr[OPC_MSB:OPC_LSB];
        is_ldi  = (opcode == OP_LDI);
        is_halt = (opcode == OP_HALT);
        rd      = instr[RD_MSB:RD_LSB];
        imm     = instr[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/glob_reg_loader.sv
// Load sequencer: fetches from a private instruction memory and turns LDI
// instructions into global register writes, paced by scheduler step pulses.
module glob_reg_loader
    import glob_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned INSTR_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [PC_WIDTH-1:0]    start_pc,
    input  logic                   step,
    output logic                   imem_rd_en,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   glob_reg_write_en,
    output logic [3:0]             glob_reg_write_addr,
    output logic [DATA_WIDTH-1:0]  glob_reg_write_data,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   busy,
    output logic                   halted,
    output logic                   step_overrun
);

    state_e                  state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic                    pending_q, pending_d;
    logic                    overrun_q, overrun_d;
    logic                    rd_en_q, rd_en_d;
    logic                    we_q, we_d;
    logic [REG_ADDR_W-1:0]   wa_q, wa_d;
    logic [DATA_WIDTH-1:0]   wd_q, wd_d;

    logic                    dec_is_ldi;
    logic                    dec_is_halt;
    logic [REG_ADDR_W-1:0]   dec_rd;
    logic [DATA_WIDTH-1:0]   dec_imm;

    glob_instr_decode #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_decode (
        .instr   (imem_rdata),
        .is_ldi  (dec_is_ldi),
        .is_halt (dec_is_halt),
        .rd      (dec_rd),
        .imm     (dec_imm)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            rd_en_q   <= 1'b0;
            we_q      <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            rd_en_q   <= rd_en_d;
            we_q      <= we_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        we_d      = 1'b0;
        wa_d      = wa_q;
        wd_d      = wd_q;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    pc_d      = start_pc;
                    pending_d = 1'b0;
                    overrun_d = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
                if (step) begin
                    if (pending_q) overrun_d = 1'b1;
                    else           pending_d = 1'b1;
                end
            end
            ST_DECODE: begin
                if (step) begin
                    if (pending_q) overrun_d = 1'b1;
                    else           pending_d = 1'b1;
                end
                if (dec_is_halt) begin
                    // Nothing left to pace, so a banked step is discarded.
                    pending_d = 1'b0;
                    state_d   = ST_HALTED;
                end else begin
                    if (dec_is_ldi) begin
                        we_d = 1'b1;
                        wa_d = dec_rd;
                        wd_d = dec_imm;
                    end
                    state_d = ST_WAIT_STEP;
                end
            end
            ST_WAIT_STEP: begin
                if (step && pending_q) overrun_d = 1'b1;
                if (step || pending_q) begin
                    pc_d      = pc_q + PC_WIDTH'(1);
                    pending_d = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rd_en_d = (state_d == ST_FETCH);
    end

    assign imem_rd_en          = rd_en_q;
    assign imem_addr           = pc_q;
    assign glob_reg_write_en   = we_q;
    assign glob_reg_write_addr = wa_q;
    assign glob_reg_write_data = wd_q;
    assign pc                  = pc_q;
    assign step_overrun        = overrun_q;
    assign busy   = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_WAIT_STEP);
    assign halted = (state_q == ST_HALTED);

endmodule

// File: tb/tb_glob_reg_loader.sv
// Directed self-checking bench for glob_reg_loader with a synchronous
// instruction memory model.
module tb_glob_reg_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  start_pc;
    logic        step;
    logic        imem_rd_en;
    logic [7:0]  imem_addr;
    logic [23:0] imem_rdata;
    logic        glob_reg_write_en;
    logic [3:0]  glob_reg_write_addr;
    logic [15:0] glob_reg_write_data;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        step_overrun;

    logic [23:0] mem [256];
    int vectors;
    int miscompares;

    glob_reg_loader dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .start_pc            (start_pc),
        .step                (step),
        .imem_rd_en          (imem_rd_en),
        .imem_addr           (imem_addr),
        .imem_rdata          (imem_rdata),
        .glob_reg_write_en   (glob_reg_write_en),
        .glob_reg_write_addr (glob_reg_write_addr),
        .glob_reg_write_data (glob_reg_write_data),
        .pc                  (pc),
        .busy                (busy),
        .halted              (halted),
        .step_overrun        (step_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
    end

    function automatic logic [23:0] ins(input logic [3:0] op, input logic [3:0] rd, input logic [15:0] imm);
        return {op, rd, imm};
    endfunction

    task automatic do_reset();
        start = 1'b0;
        step  = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Returns in the middle of cycle 1 (start sampled at edge 0).
    task automatic do_start(input logic [7:0] p);
        start    = 1'b1;
        start_pc = p;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; step = 1'b0; start_pc = 8'h00;
        @(negedge clk);
        vectors++; if (imem_rd_en !== 1'b0) begin miscompares++; $display("FAIL rst_rd_en got %b want 0", imem_rd_en); end
        vectors++; if (glob_reg_write_en !== 1'b0) begin miscompares++; $display("FAIL rst_we got %b want 0", glob_reg_write_en); end
        vectors++; if (glob_reg_write_addr !== 4'h0) begin miscompares++; $display("FAIL rst_wa got %h want 0", glob_reg_write_addr); end
        vectors++; if (glob_reg_write_data !== 16'h0) begin miscompares++; $display("FAIL rst_wd got %h want 0", glob_reg_write_data); end
        vectors++; if (pc !== 8'h00) begin miscompares++; $display("FAIL rst_pc got %h want 00", pc); end
        vectors++; if ({busy, halted, step_overrun} !== 3'b000) begin miscompares++; $display("FAIL rst_flags got %b want 000", {busy, halted, step_overrun}); end
        reset = 1'b0;
        step  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        step = 1'b0;
        vectors++; if ({busy, imem_rd_en, step_overrun} !== 3'b000) begin miscompares++; $display("FAIL idle_step got %b want 000", {busy, imem_rd_en, step_overrun}); end
        vectors++; if (pc !== 8'h00) begin miscompares++; $display("FAIL idle_pc got %h want 00", pc); end
    endtask

    task automatic test_ldi_latency();
        do_reset();
        do_start(8'h10);
        vectors++; if (imem_rd_en !== 1'b1 || imem_addr !== 8'h10) begin miscompares++; $display("FAIL lat_c1 got rd_en=%b addr=%h want 1/10", imem_rd_en, imem_addr); end
        vectors++; if (busy !== 1'b1 || glob_reg_write_en !== 1'b0) begin miscompares++; $display("FAIL lat_c1_busy got busy=%b we=%b want 1/0", busy, glob_reg_write_en); end
        @(negedge clk);
        vectors++; if (imem_rd_en !== 1'b0 || glob_reg_write_en !== 1'b0) begin miscompares++; $display("FAIL lat_c2 got rd_en=%b we=%b want 0/0", imem_rd_en, glob_reg_write_en); end
        @(negedge clk);
        vectors++; if (glob_reg_write_en !== 1'b1) begin miscompares++; $display("FAIL lat_c3_we got %b want 1", glob_reg_write_en); end
        vectors++; if (glob_reg_write_addr !== 4'h3 || glob_reg_write_data !== 16'hBEEF) begin miscompares++; $display("FAIL lat_c3_wr got addr=%h data=%h want 3/beef", glob_reg_write_addr, glob_reg_write_data); end
        @(negedge clk);
        vectors++; if (glob_reg_write_en !== 1'b0) begin miscompares++; $display("FAIL lat_c4_we got %b want 0", glob_reg_write_en); end
        vectors++; if (busy !== 1'b1 || pc !== 8'h10 || imem_rd_en !== 1'b0) begin miscompares++; $display("FAIL lat_wait got busy=%b pc=%h rd_en=%b want 1/10/0", busy, pc, imem_rd_en); end
    endtask

    task automatic test_continuous_step();
        logic [14:0] exp_rd, exp_we, exp_halt;
        exp_rd   = 15'b000_0010_0100_1001;
        exp_we   = 15'b000_0001_0000_0100;
        exp_halt = 15'b111_1000_0000_0000;
        do_reset();
        do_start(8'h00);
        step = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            vectors++; if (imem_rd_en !== exp_rd[c-1]) begin miscompares++; $display("FAIL cont_rd_en c%0d got %b want %b", c, imem_rd_en, exp_rd[c-1]); end
            vectors++; if (glob_reg_write_en !== exp_we[c-1]) begin miscompares++; $display("FAIL cont_we c%0d got %b want %b", c, glob_reg_write_en, exp_we[c-1]); end
            vectors++; if (halted !== exp_halt[c-1]) begin miscompares++; $display("FAIL cont_halted c%0d got %b want %b", c, halted, exp_halt[c-1]); end
            if (c == 3) begin
                vectors++; if (glob_reg_write_addr !== 4'h0 || glob_reg_write_data !== 16'h0001) begin miscompares++; $display("FAIL cont_wr0 got %h/%h want 0/0001", glob_reg_write_addr, glob_reg_write_data); end
            end
            if (c == 9) begin
                vectors++; if (glob_reg_write_addr !== 4'hF || glob_reg_write_data !== 16'hFFFF) begin miscompares++; $display("FAIL cont_wr15 got %h/%h want f/ffff", glob_reg_write_addr, glob_reg_write_data); end
            end
            if (c == 10) begin
                vectors++; if (imem_addr !== 8'h03) begin miscompares++; $display("FAIL cont_halt_addr got %h want 03", imem_addr); end
            end
            if (c >= 12) begin
                vectors++; if (pc !== 8'h03 || busy !== 1'b0) begin miscompares++; $display("FAIL cont_halt_pc c%0d got pc=%h busy=%b want 03/0", c, pc, busy); end
            end
            @(negedge clk);
        end
        step = 1'b0;
    endtask

    task automatic test_pending_step();
        do_reset();
        do_start(8'h20);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        vectors++; if (imem_rd_en !== 1'b0 || pc !== 8'h20) begin miscompares++; $display("FAIL pend_c3 got rd_en=%b pc=%h want 0/20", imem_rd_en, pc); end
        @(negedge clk);
        vectors++; if (imem_rd_en !== 1'b1 || imem_addr !== 8'h21) begin miscompares++; $display("FAIL pend_c4 got rd_en=%b addr=%h want 1/21", imem_rd_en, imem_addr); end
        repeat (3) @(negedge clk);
        vectors++; if (imem_rd_en !== 1'b0 || pc !== 8'h21 || busy !== 1'b1) begin miscompares++; $display("FAIL pend_c7 got rd_en=%b pc=%h busy=%b want 0/21/1", imem_rd_en, pc, busy); end
        vectors++; if (step_overrun !== 1'b0) begin miscompares++; $display("FAIL pend_overrun got %b want 0", step_overrun); end
    endtask

    task automatic test_overrun();
        do_reset();
        do_start(8'h30);
        step = 1'b1;
        @(negedge clk);
        vectors++; if (step_overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_c2 got %b want 0", step_overrun); end
        @(negedge clk);
        step = 1'b0;
        vectors++; if (step_overrun !== 1'b1 || pc !== 8'h30) begin miscompares++; $display("FAIL ovr_c3 got ovr=%b pc=%h want 1/30", step_overrun, pc); end
        @(negedge clk);
        vectors++; if (imem_rd_en !== 1'b1 || imem_addr !== 8'h31) begin miscompares++; $display("FAIL ovr_c4 got rd_en=%b addr=%h want 1/31", imem_rd_en, imem_addr); end
        repeat (2) @(negedge clk);
        vectors++; if (halted !== 1'b1 || pc !== 8'h31 || step_overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_c6 got halted=%b pc=%h ovr=%b want 1/31/1", halted, pc, step_overrun); end
        do_start(8'h30);
        vectors++; if (step_overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_clear got %b want 0", step_overrun); end
        vectors++; if (imem_rd_en !== 1'b1 || imem_addr !== 8'h30 || halted !== 1'b0) begin miscompares++; $display("FAIL ovr_restart got rd_en=%b addr=%h halted=%b want 1/30/0", imem_rd_en, imem_addr, halted); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        do_start(8'hFF);
        vectors++; if (imem_addr !== 8'hFF) begin miscompares++; $display("FAIL wrap_c1 got %h want ff", imem_addr); end
        repeat (2) @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        vectors++; if (imem_rd_en !== 1'b1 || imem_addr !== 8'h00 || pc !== 8'h00) begin miscompares++; $display("FAIL wrap_c4 got rd_en=%b addr=%h pc=%h want 1/00/00", imem_rd_en, imem_addr, pc); end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        do_start(8'h10);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        vectors++; if (glob_reg_write_en !== 1'b1) begin miscompares++; $display("FAIL rmw_pre got %b want 1", glob_reg_write_en); end
        #1 reset = 1'b1;
        #1;
        vectors++; if (glob_reg_write_en !== 1'b0) begin miscompares++; $display("FAIL rmw_we got %b want 0", glob_reg_write_en); end
        vectors++; if (busy !== 1'b0 || halted !== 1'b0 || pc !== 8'h00) begin miscompares++; $display("FAIL rmw_state got busy=%b halted=%b pc=%h want 0/0/00", busy, halted, pc); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_start(8'h20);
        vectors++; if (imem_rd_en !== 1'b1 || imem_addr !== 8'h20) begin miscompares++; $display("FAIL rmw_restart got rd_en=%b addr=%h want 1/20", imem_rd_en, imem_addr); end
        repeat (3) @(negedge clk);
        vectors++; if (imem_rd_en !== 1'b0 || pc !== 8'h20 || busy !== 1'b1) begin miscompares++; $display("FAIL rmw_nopend got rd_en=%b pc=%h busy=%b want 0/20/1", imem_rd_en, pc, busy); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start       = 1'b0;
        start_pc    = 8'h00;
        step        = 1'b0;
        imem_rdata  = 24'h0;
        for (int i = 0; i < 256; i++) mem[i] = 24'h0;
        mem[8'h00] = ins(4'h1, 4'h0, 16'h0001);
        mem[8'h01] = ins(4'h0, 4'h0, 16'h0000);
        mem[8'h02] = ins(4'h1, 4'hF, 16'hFFFF);
        mem[8'h03] = ins(4'hF, 4'h0, 16'h0000);
        mem[8'h10] = ins(4'h1, 4'h3, 16'hBEEF);
        mem[8'h20] = ins(4'h0, 4'h0, 16'h0000);
        mem[8'h21] = ins(4'h7, 4'h2, 16'h1234);
        mem[8'h30] = ins(4'h0, 4'h0, 16'h0000);
        mem[8'h31] = ins(4'hF, 4'h0, 16'h0000);
        mem[8'hFF] = ins(4'h0, 4'h0, 16'h0000);

        test_reset();
        test_ldi_latency();
        test_continuous_step();
        test_pending_step();
        test_overrun();
        test_pc_wrap();
        test_reset_mid_write();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/glob_reg_loader.md
# glob_reg_loader

Scalar load sequencer that fills the compute unit's 16-entry global register file. It owns a private program counter and fetches from its own synchronous instruction memory. It decodes load-immediate instructions into single-cycle write transactions on the global register write port. It advances one instruction per `step` pulse from the thread scheduler, so it stays in lock-step with the thread PCs.

## Interface
Parameters:
- DATA_WIDTH, 16, width of immediate and register write data
- PC_WIDTH, 8, loader program counter width
- INSTR_WIDTH, 24, instruction word width: [23:20] opcode, [19:16] rd, [15:0] imm

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins execution at start_pc
- start_pc  in  PC_WIDTH  entry point, sampled with start
- step  in  1  one-cycle pulse from scheduler: threads advanced one instruction
- imem_rd_en  out  1  instruction memory read strobe
- imem_addr  out  PC_WIDTH  instruction memory address
- imem_rdata  in  INSTR_WIDTH  instruction word, valid the cycle after imem_rd_en
- glob_reg_write_en  out  1  global register write strobe, one cycle wide
- glob_reg_write_addr  out  4  destination register
- glob_reg_write_data  out  DATA_WIDTH  immediate to write
- pc  out  PC_WIDTH  current loader PC
- busy  out  1  high in FETCH, DECODE, WAIT_STEP
- halted  out  1  high in HALTED
- step_overrun  out  1  sticky error flag; cleared by reset or start

## Operation
- Opcodes:
  - 4'h0 NOP.
  - 4'h1 LDI: reg[rd] <= imm.
  - 4'hF HALT.
  - All other opcodes execute as NOP. Thread-side opcodes are not this block's concern.
- FSM states: IDLE, FETCH, DECODE, WAIT_STEP, HALTED.
  - IDLE, start: pc <= start_pc, go to FETCH.
  - FETCH: imem_rd_en=1, imem_addr=pc; go to DECODE.
  - DECODE: latch imem_rdata.
    - HALT: go to HALTED. No write; pc is unchanged.
    - LDI: register write_en=1, write_addr=rd, write_data=imem_rdata[DATA_WIDTH-1:0]; go to WAIT_STEP.
    - Any other opcode: go to WAIT_STEP.
  - WAIT_STEP, on step or step_pending: pc <= pc+1, clear pending, go to FETCH.
  - HALTED: start restarts exactly as from IDLE.
- step handling:
  - A step seen in FETCH or DECODE sets step_pending.
  - A step seen while step_pending is already set sets step_overrun. That step is dropped; at most one step is ever pending.
  - A step seen in IDLE or HALTED is ignored.
- start is ignored in FETCH, DECODE and WAIT_STEP.
- PC arithmetic is modulo 2^PC_WIDTH: pc = all-ones steps to 0.
- A HALT fetched while step_pending is set clears step_pending.
- imem_addr is driven from pc in all states; only imem_rd_en qualifies it.

## Timing
- Reset (async) values:
  - state = IDLE; pc = 0.
  - imem_rd_en = 0; glob_reg_write_en = 0.
  - glob_reg_write_addr = 0; glob_reg_write_data = 0.
  - busy = 0; halted = 0; step_overrun = 0; step_pending = 0.
- Reset mid-operation drops any in-flight write. write_en falls immediately, without waiting for a clock edge.
- Latency, with start sampled at edge 0:
  - imem_rd_en high in cycle 1.
  - rdata sampled at edge 2.
  - glob_reg_write_en high in cycle 3, the first WAIT_STEP cycle.
  - The register file commits the write at edge 4.
- step sampled in WAIT_STEP at edge N gives FETCH in cycle N+1.
- Minimum instruction period is 3 cycles. A scheduler pulsing step faster than that overruns.
- glob_reg_write_en is never high for more than one consecutive cycle.
- All outputs are registered, except busy and halted, which are state decodes.

## Structure
- Shared package glob_loader_pkg holds:
  - opcode constants OP_NOP, OP_LDI, OP_HALT;
  - instruction field bit positions;
  - the state enum encoding.
- Optional sub-module glob_instr_decode: combinational, opcode/rd/imm to is_ldi, is_halt, rd, imm. It is reused by later scalar-side blocks.
- The FSM, PC, step_pending/overrun logic and output registers live in the top module.

## Test plan
- Reset, then start with start_pc=8'h10; imem[0x10]=LDI r3,16'hBEEF -> imem_rd_en in cycle 1 with addr 0x10; write_en=1, addr=3, data=16'hBEEF in cycle 3 only.
- Program LDI r0,1 / NOP / LDI r15,16'hFFFF / HALT, step held high continuously -> writes r0 then r15, 3-cycle instruction spacing, halted=1 with pc=3 (HALT address, start_pc=0), step then ignored.
- step pulse in FETCH, then no further steps -> pending consumed; FETCH of pc+1 occurs on the cycle after WAIT_STEP is entered; step_overrun stays 0.
- Two step pulses during one FETCH/DECODE window -> step_overrun=1 (sticky); exactly one pc advance; start clears the flag.
- start_pc=8'hFF, instruction NOP, then step -> pc wraps to 8'h00 and imem_addr=0x00 in the next FETCH.
- Assert reset during the write_en cycle -> write_en low immediately; state IDLE; a later start re-runs from start_pc with no residual pending step.
